serframe_rx: RTL and testbench
==============================

Name: serframe_rx

Overview:
- Downstream consumer of the serial test stream: sdata with svalid qualifier, plus an sfs pulse marking the first bit of each FRAME_BITS-bit frame.
- Hunts for and verifies frame alignment, then deserializes the locked stream MSB-first into WORD_W-bit words.
- Words leave through a small FIFO on a valid/ready interface, with a start-of-frame flag.
- Reports lock state and sync/overflow errors to the bench/datapath.

Parameters:
- WORD_W, 32: output word width; must divide FRAME_BITS.
- FRAME_BITS, 256: bits per frame; power of two, at least 2*WORD_W.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- LOCK_FRAMES, 2: consecutive correctly placed sfs pulses needed after the first to declare lock.

Ports:
- sclk  in  1  clock; all logic on posedge.
- rstn  in  1  reset; synchronous, active-low (sampled on posedge sclk).
- svalid  in  1  serial bit qualifier; sdata/sfs ignored when low.
- sdata  in  1  serial data bit.
- sfs  in  1  frame start; high with the first bit of a frame.
- word_data  out  WORD_W  FIFO head word.
- word_sof  out  1  head word is word 0 of a frame.
- word_valid  out  1  FIFO non-empty.
- word_ready  in  1  consumer accept; pop when valid&&ready.
- locked  out  1  state==LOCKED.
- sync_err  out  1  one-cycle pulse on loss of lock.
- ovf  out  1  one-cycle pulse when a completed word is dropped on a full FIFO.

Behaviour:
- Reset (rstn low at posedge):
  - state=HUNT; bit counter, good counter and shift register = 0; FIFO emptied.
  - All outputs 0, including word_data and word_sof.
  - Reset mid-frame discards the partial word and all FIFO contents.
- Bit index: bidx counts 0..FRAME_BITS-1 and advances only on svalid cycles. Wraps FRAME_BITS-1 -> 0. "Expected boundary" means bidx==0.
- State HUNT:
  - Bits discarded.
  - On svalid&&sfs: bidx <= 1, good <= 0, go VERIFY.
- State VERIFY:
  - Tracks bidx; no words emitted.
  - At an svalid cycle with bidx==0 and sfs: good++. When good+1==LOCK_FRAMES, go LOCKED; this sfs bit is bit 0 of word 0 and is shifted in.
  - svalid&&sfs with bidx!=0, or svalid&&!sfs with bidx==0: go HUNT, no sync_err.
  - Exception: an sfs seen at bidx!=0 restarts VERIFY in the same cycle with bidx <= 1, good <= 0.
- State LOCKED:
  - Each svalid bit shifts into the shift register MSB-first; the first bit of each word lands in word bit WORD_W-1.
  - When bidx%WORD_W == WORD_W-1, the completed word (shift register plus current bit) is pushed. The same edge sets sof = (bidx==WORD_W-1).
  - word_valid is high on the cycle after the last bit's sampling edge when the FIFO was empty.
  - Sync violation: sfs at bidx!=0, or missing sfs at bidx==0.
    - Raises sync_err for 1 cycle and goes HUNT.
    - Discards the partial word; words already in the FIFO remain poppable.
    - A misplaced sfs does not relock directly; it restarts VERIFY as above.
- FIFO:
  - Push and pop in the same cycle are both performed, including when full (no ovf) and when empty is impossible (pop requires valid).
  - Push when full without a pop: word dropped, ovf pulses 1 cycle, contents unchanged.
  - word_data/word_sof are stable while valid&&!ready.
- svalid low: holds all state; no counters advance; sfs is ignored.

Optional Feature:
- Macro SERFRAME_RX_ERRCNT_EN.
- When defined:
  - Adds output err_cnt, 16 bits: saturating count of sync_err plus ovf events. If both fire in the same cycle, add 2, saturating at 16'hFFFF.
  - Adds input err_clr, 1 bit: synchronous clear; clear wins over a same-cycle increment.
  - Both reset to 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- serframe_pkg holds:
  - state encoding constants ST_HUNT=2'd0, ST_VERIFY=2'd1, ST_LOCKED=2'd2;
  - default WORD_W/FRAME_BITS/FIFO_DEPTH;
  - derived widths BIDX_W=log2(FRAME_BITS) and PTR_W=log2(FIFO_DEPTH).
- One sub-module, serframe_fifo: synchronous FIFO, WORD_W+1 bits wide (data+sof), with full/empty via PTR_W+1 pointers. Sync/deserialize FSM stays in serframe_rx.

Test Plan:
- Clean stream, LOCK_FRAMES=2, sfs every 256 svalid bits, word_ready=1:
  - locked rises after the 3rd sfs is sampled;
  - first word has word_sof=1 and equals bits 0..31 of that frame MSB-first (e.g. 32'hDEADBEEF);
  - exactly 8 words per frame, with sof on every 8th.
- Misplaced sfs at bidx=100 while LOCKED:
  - sync_err pulses once; locked falls the next cycle;
  - no further words until relock two full frames later.
- word_ready=0 for 6 words with FIFO_DEPTH=4:
  - 4 words held unchanged, ovf pulses exactly twice, word 5 and 6 lost;
  - after ready=1, the next popped word is the following frame word in order.
- svalid toggled 50% randomly on a clean stream: output words are identical to the svalid=1 run; bidx never advances on svalid=0 cycles.
- rstn low for one cycle mid-frame while LOCKED with 2 words queued:
  - next cycle word_valid=0, locked=0, sync_err=0;
  - relocks normally.
- With SERFRAME_RX_ERRCNT_EN:
  - 3 misplaced sfs plus 2 overflows give err_cnt=5;
  - err_clr in the same cycle as an ovf gives err_cnt=0.

Source files
------------

// File: rtl/serframe_pkg.sv
// Shared definitions for the serial frame receiver: state encoding and default geometry.
package serframe_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FRAME_BITS = 256;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int BIDX_W         = $clog2(DEF_FRAME_BITS);
  localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

endpackage

// File: rtl/serframe_fifo.sv
// Small synchronous FIFO carrying {sof, word}; full/empty from extended pointers.
// Head data reads as zero while empty so the port is quiet after reset.
module serframe_fifo
  import serframe_pkg::*;
#(
  parameter int W     = DEF_WORD_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int PW    = PTR_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot this cycle, so a full FIFO still accepts the push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/serframe_rx.sv
// Serial frame receiver: hunts/verifies sfs alignment, deserializes MSB-first into a FIFO.
// Optional SERFRAME_RX_ERRCNT_EN adds a saturating sync/overflow event counter (err_cnt, err_clr).
module serframe_rx
  import serframe_pkg::*;
#(
  parameter int WORD_W      = DEF_WORD_W,
  parameter int FRAME_BITS  = DEF_FRAME_BITS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              svalid,
  input  logic              sdata,
  input  logic              sfs,
  output logic [WORD_W-1:0] word_data,
  output logic              word_sof,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              locked,
  output logic              sync_err,
`ifdef SERFRAME_RX_ERRCNT_EN
  output logic [15:0]       err_cnt,
  input  logic              err_clr,
`endif
  output logic              ovf
);

  localparam int BW     = (FRAME_BITS == DEF_FRAME_BITS) ? BIDX_W : $clog2(FRAME_BITS);
  localparam int PW     = (FIFO_DEPTH == DEF_FIFO_DEPTH) ? PTR_W : $clog2(FIFO_DEPTH);
  localparam int WB     = $clog2(WORD_W);
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  state_t              state_q, state_d;
  logic [BW-1:0]       bidx_q, bidx_d;
  logic [GOOD_W-1:0]   good_q, good_d;
  logic [WORD_W-2:0]   shift_q, shift_d;
  logic                sync_err_q, sync_err_d;
  logic                ovf_q;
  logic [WORD_W-1:0]   word_full;
  logic                push, pop, fifo_full, fifo_empty, sof_push;
  logic [WORD_W:0]     fifo_dout;

  assign word_full = {shift_q, sdata};
  assign sof_push  = (bidx_q == BW'(WORD_W - 1));

  always_comb begin
    state_d    = state_q;
    bidx_d     = bidx_q;
    good_d     = good_q;
    shift_d    = shift_q;
    sync_err_d = 1'b0;
    push       = 1'b0;
    if (svalid) begin
      case (state_q)
        ST_HUNT: begin
          if (sfs) begin
            state_d = ST_VERIFY;
            bidx_d  = BW'(1);
            good_d  = '0;
          end
        end
        ST_VERIFY: begin
          if (bidx_q == '0) begin
            if (sfs) begin
              bidx_d = BW'(1);
              if (good_q == GOOD_W'(LOCK_FRAMES - 1)) begin
                // The locking sfs bit is already bit 0 of word 0.
                state_d = ST_LOCKED;
                good_d  = '0;
                shift_d = word_full[WORD_W-2:0];
              end else begin
                good_d = good_q + 1'b1;
              end
            end else begin
              state_d = ST_HUNT;
              bidx_d  = '0;
            end
          end else if (sfs) begin
            bidx_d = BW'(1);
            good_d = '0;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (sfs != (bidx_q == '0)) begin
            sync_err_d = 1'b1;
            shift_d    = '0;
            good_d     = '0;
            if (sfs) begin
              state_d = ST_VERIFY;
              bidx_d  = BW'(1);
            end else begin
              state_d = ST_HUNT;
              bidx_d  = '0;
            end
          end else begin
            shift_d = word_full[WORD_W-2:0];
            bidx_d  = bidx_q + 1'b1;
            push    = &bidx_q[WB-1:0];
          end
        end
        default: begin
          state_d = ST_HUNT;
          bidx_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sclk) begin
    if (!rstn) begin
      state_q    <= ST_HUNT;
      bidx_q     <= '0;
      good_q     <= '0;
      shift_q    <= '0;
      sync_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bidx_q     <= bidx_d;
      good_q     <= good_d;
      shift_q    <= shift_d;
      sync_err_q <= sync_err_d;
      ovf_q      <= push && fifo_full && !pop;
    end
  end

  serframe_fifo #(
    .W     (WORD_W + 1),
    .DEPTH (FIFO_DEPTH),
    .PW    (PW)
  ) u_fifo (
    .clk     (sclk),
    .rstn    (rstn),
    .push_i  (push),
    .data_i  ({sof_push, word_full}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop        = word_valid && word_ready;
  assign word_valid = !fifo_empty;
  assign word_sof   = fifo_dout[WORD_W];
  assign word_data  = fifo_dout[WORD_W-1:0];
  assign locked     = (state_q == ST_LOCKED);
  assign sync_err   = sync_err_q;
  assign ovf        = ovf_q;

`ifdef SERFRAME_RX_ERRCNT_EN
  logic [15:0] err_cnt_q;
  logic [16:0] err_sum;

  // Counts the visible pulses, so a clear held during a pulse cycle drops that event.
  assign err_sum = {1'b0, err_cnt_q} + 17'(sync_err_q) + 17'(ovf_q);

  always_ff @(posedge sclk) begin
    if (!rstn || err_clr) err_cnt_q <= '0;
    else if (err_sum[16]) err_cnt_q <= 16'hFFFF;
    else                  err_cnt_q <= err_sum[15:0];
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_serframe_rx.sv
// Directed bench for serframe_rx: lock, misalignment, backpressure, gapped svalid, reset.
// Frame content is a fixed function of (frame, word); expected words come from that table.
module tb_serframe_rx;

  logic        sclk = 1'b0;
  logic        rstn, svalid, sdata, sfs, word_ready;
  logic [31:0] word_data;
  logic        word_sof, word_valid, locked, sync_err, ovf;
`ifdef SERFRAME_RX_ERRCNT_EN
  logic [15:0] err_cnt;
  logic        err_clr;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int tx_frame = 0;
  int tx_bit   = 0;
  bit inj_sfs  = 1'b0;
  int ovf_seen = 0;
  int serr_seen = 0;
  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  serframe_rx #(
    .WORD_W(32), .FRAME_BITS(256), .FIFO_DEPTH(4), .LOCK_FRAMES(2)
  ) dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .svalid     (svalid),
    .sdata      (sdata),
    .sfs        (sfs),
    .word_data  (word_data),
    .word_sof   (word_sof),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .locked     (locked),
    .sync_err   (sync_err),
`ifdef SERFRAME_RX_ERRCNT_EN
    .err_cnt    (err_cnt),
    .err_clr    (err_clr),
`endif
    .ovf        (ovf)
  );

  initial forever #5 sclk = ~sclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  // Popped words and error pulses, sampled on the falling edge.
  always @(negedge sclk) begin
    if (rstn) begin
      if (word_valid && word_ready) got_q.push_back({word_sof, word_data});
      if (ovf) ovf_seen++;
      if (sync_err) serr_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] frame_word(input int f, input int w);
    if (f == 2 && w == 0) return 32'hDEADBEEF;
    return {f[7:0], w[7:0], 8'h5A, 8'(f * 7 + w * 13)};
  endfunction

  function automatic logic fbit(input int f, input int b);
    logic [31:0] wd;
    wd = frame_word(f, b / 32);
    return wd[31 - (b % 32)];
  endfunction

  task automatic step(input bit v);
    if (v) begin
      sdata   = fbit(tx_frame, tx_bit);
      sfs     = (tx_bit == 0) ^ inj_sfs;
      inj_sfs = 1'b0;
      tx_bit++;
      if (tx_bit == 256) begin
        tx_bit = 0;
        tx_frame++;
      end
    end else begin
      sdata = 1'($urandom);
      sfs   = 1'($urandom);
    end
    svalid = v;
    @(posedge sclk);
    #1;
  endtask

  task automatic send_until(input int f, input int b, input bit rnd);
    int guard = 0;
    while (!(tx_frame == f && tx_bit == b)) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      guard++;
      if (guard > 20000) begin
        $display("FAIL send_until: got no progress, expected frame %0d bit %0d", f, b);
        $fatal(1, "stuck");
      end
    end
  endtask

  task automatic exp_words(input int f, input int w0, input int w1);
    for (int w = w0; w <= w1; w++) exp_q.push_back({w == 0, frame_word(f, w)});
  endtask

  initial begin
    rstn = 1'b0; svalid = 1'b0; sdata = 1'b0; sfs = 1'b0; word_ready = 1'b1;
`ifdef SERFRAME_RX_ERRCNT_EN
    err_clr = 1'b0;
`endif
    repeat (3) step(1'b0);
    chk("rst_locked", locked, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_data", word_data, 0);
    chk("rst_sof", word_sof, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_ovf", ovf, 0);
    rstn = 1'b1;
    step(1'b0);

    // Clean stream: lock on the third sfs.
    send_until(2, 0, 1'b0);
    chk("prelock_locked", locked, 0);
    step(1'b1);
    chk("lock_locked", locked, 1);
    send_until(2, 31, 1'b0);
    chk("w0_not_yet", word_valid, 0);
    step(1'b1);
    chk("w0_valid", word_valid, 1);
    chk("w0_data", word_data, 32'hDEADBEEF);
    chk("w0_sof", word_sof, 1);
    exp_words(2, 0, 7);
    exp_words(3, 0, 7);

    // Misplaced sfs at bit 100 while locked.
    send_until(4, 100, 1'b0);
    inj_sfs = 1'b1;
    step(1'b1);
    chk("mis_sync_err", sync_err, 1);
    chk("mis_locked", locked, 0);
    step(1'b1);
    chk("mis_sync_err_end", sync_err, 0);
    exp_words(4, 0, 2);
    send_until(7, 0, 1'b0);
    chk("relock_early", locked, 0);
    chk("serr_count", serr_seen, 1);
    word_ready = 1'b0;
    step(1'b1);
    chk("relock_locked", locked, 1);

    // Backpressure: six words against a four-entry FIFO.
    send_until(7, 192, 1'b0);
    chk("bp_ovf_pulse", ovf, 1);
    chk("bp_valid", word_valid, 1);
    chk("bp_head_data", word_data, frame_word(7, 0));
    chk("bp_head_sof", word_sof, 1);
    word_ready = 1'b1;
    exp_words(7, 0, 3);
    exp_words(7, 6, 7);
    send_until(8, 0, 1'b0);
    chk("bp_ovf_count", ovf_seen, 2);

    // Gapped svalid with random sfs/sdata on idle cycles.
    send_until(10, 4, 1'b1);
    exp_words(8, 0, 7);
    exp_words(9, 0, 7);

    // Reset mid-frame with two words queued.
    word_ready = 1'b0;
    send_until(10, 80, 1'b0);
    chk("prerst_valid", word_valid, 1);
    rstn = 1'b0;
    step(1'b1);
    rstn = 1'b1;
    chk("mrst_valid", word_valid, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_sync_err", sync_err, 0);
    chk("mrst_data", word_data, 0);
    word_ready = 1'b1;
    send_until(13, 1, 1'b0);
    chk("mrst_relock", locked, 1);
    send_until(14, 0, 1'b0);
    exp_words(13, 0, 7);
    repeat (3) step(1'b0);

    chk("n_words", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("word%0d", i), got_q[i], exp_q[i]);

`ifdef SERFRAME_RX_ERRCNT_EN
    chk("ec_start", err_cnt, 0);
    for (int k = 0; k < 3; k++) begin
      send_until(14 + 3 * k, 100, 1'b0);
      inj_sfs = 1'b1;
      send_until(17 + 3 * k, 1, 1'b0);
      chk($sformatf("ec_relock%0d", k), locked, 1);
    end
    chk("ec_after_sync", err_cnt, 3);
    word_ready = 1'b0;
    send_until(23, 193, 1'b0);
    chk("ec_five", err_cnt, 5);
    send_until(23, 224, 1'b0);
    chk("ec_ovf3_pulse", ovf, 1);
    err_clr = 1'b1;
    step(1'b1);
    err_clr = 1'b0;
    chk("ec_clear_wins", err_cnt, 0);
    step(1'b1);
    chk("ec_stays_clear", err_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
